// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - snapshot-based shot/asteroid/ship collision scanner
module collision_detector #(
  parameter int ENTITY_SIZE   = 34,
  parameter int MAX_SHOTS     = 3,
  parameter int MAX_ASTEROIDS = 4,
  parameter int SHOT_SIZE     = 2,
  parameter int ASTEROID_SIZE = 16,
  parameter int SHIP_SIZE     = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic [ENTITY_SIZE-1:0]              ship,
  input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]    shots,
  input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroids,
  input  logic                                ack,
  output logic                                delete_shot,
  output logic [1:0]                          shot_address,
  output logic                                delete_asteroid,
  output logic [1:0]                          asteroid_address,
  output logic                                ship_hit,
  output logic                                busy,
  output logic                                done,
  output logic [7:0]                          hit_count
);

  // Shot index runs one past the last shot; that value selects the ship phase.
  localparam int SW = $clog2(MAX_SHOTS + 1);
  localparam int AW = (MAX_ASTEROIDS > 1) ? $clog2(MAX_ASTEROIDS) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, CHECK, REPORT, DONE} state_e;

  typedef struct packed {
    logic       act;
    logic [9:0] y;
    logic [9:0] x;
  } ent_t;

  state_e          state_q, state_d;
  ent_t            ship_q;
  ent_t            shot_q [MAX_SHOTS];
  ent_t            ast_q  [MAX_ASTEROIDS];
  logic [SW-1:0]   sidx_q, sidx_d;
  logic [AW-1:0]   aidx_q, aidx_d;
  logic            del_q, del_d;
  logic [1:0]      shot_addr_q, shot_addr_d;
  logic [1:0]      ast_addr_q, ast_addr_d;
  logic            ship_hit_q, ship_hit_d;
  logic            busy_q;
  logic            done_q, done_d;
  logic [7:0]      count_q, count_d;
  logic            latch_en, clear_en;
  logic            ship_phase, last_ast, pair_hit;
  logic [SW-1:0]   adv_sidx;
  logic [AW-1:0]   adv_aidx;
  ent_t            cur_a, cur_b;
  logic            unused_fields;

  function automatic ent_t decode(input logic [ENTITY_SIZE-1:0] rec);
    ent_t e;
    e.act = rec[33];
    e.y   = rec[25:16];
    e.x   = rec[15:6];
    return e;
  endfunction

  // Box overlap at 11 bits so x+size never wraps.
  function automatic logic overlap(input ent_t a, input int sa, input ent_t b, input int sb);
    logic [10:0] xa, ya, xb, yb;
    xa = {1'b0, a.x};
    ya = {1'b0, a.y};
    xb = {1'b0, b.x};
    yb = {1'b0, b.y};
    return a.act && b.act &&
           (xa < xb + 11'(sb)) && (xb < xa + 11'(sa)) &&
           (ya < yb + 11'(sb)) && (yb < ya + 11'(sa));
  endfunction

  // Direction and spare bits of each record play no part in collisions.
  always_comb begin
    unused_fields = ^{ship[32:26], ship[5:0]};
    for (int i = 0; i < MAX_SHOTS; i++)
      unused_fields = unused_fields ^ (^{shots[i*ENTITY_SIZE+26 +: 7], shots[i*ENTITY_SIZE +: 6]});
    for (int i = 0; i < MAX_ASTEROIDS; i++)
      unused_fields = unused_fields ^ (^{asteroids[i*ENTITY_SIZE+26 +: 7], asteroids[i*ENTITY_SIZE +: 6]});
  end

  // Select the current pair from the snapshot and test it.
  always_comb begin
    ship_phase = (sidx_q == SW'(MAX_SHOTS));
    last_ast   = (aidx_q == AW'(MAX_ASTEROIDS - 1));
    cur_b      = ast_q[aidx_q];
    cur_a      = ship_phase ? ship_q : shot_q[sidx_q];
    pair_hit   = overlap(cur_a, ship_phase ? SHIP_SIZE : SHOT_SIZE, cur_b, ASTEROID_SIZE);
    adv_aidx   = last_ast ? '0 : aidx_q + AW'(1);
    adv_sidx   = last_ast ? sidx_q + SW'(1) : sidx_q;
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    sidx_d      = sidx_q;
    aidx_d      = aidx_q;
    del_d       = 1'b0;
    shot_addr_d = shot_addr_q;
    ast_addr_d  = ast_addr_q;
    ship_hit_d  = 1'b0;
    done_d      = 1'b0;
    count_d     = count_q;
    latch_en    = 1'b0;
    clear_en    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = LATCH;
      LATCH: begin
        latch_en = 1'b1;
        sidx_d   = '0;
        aidx_d   = '0;
        state_d  = CHECK;
      end
      CHECK: begin
        if (ship_phase) begin
          if (pair_hit || last_ast) begin
            ship_hit_d = pair_hit;
            done_d     = 1'b1;
            state_d    = DONE;
          end else begin
            aidx_d = adv_aidx;
          end
        end else if (pair_hit) begin
          del_d       = 1'b1;
          shot_addr_d = 2'(sidx_q);
          ast_addr_d  = 2'(aidx_q);
          state_d     = REPORT;
        end else begin
          aidx_d = adv_aidx;
          sidx_d = adv_sidx;
        end
      end
      REPORT: begin
        del_d = 1'b1;
        if (ack) begin
          del_d    = 1'b0;
          clear_en = 1'b1;
          count_d  = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
          aidx_d   = adv_aidx;
          sidx_d   = adv_sidx;
          state_d  = CHECK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Pair index, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sidx_q      <= '0;
      aidx_q      <= '0;
      del_q       <= 1'b0;
      shot_addr_q <= '0;
      ast_addr_q  <= '0;
      ship_hit_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      sidx_q      <= sidx_d;
      aidx_q      <= aidx_d;
      del_q       <= del_d;
      shot_addr_q <= shot_addr_d;
      ast_addr_q  <= ast_addr_d;
      ship_hit_q  <= ship_hit_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  // Snapshot: loaded in LATCH, consumed entities lose their active bit on ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ship_q <= '0;
      for (int i = 0; i < MAX_SHOTS; i++)     shot_q[i] <= '0;
      for (int i = 0; i < MAX_ASTEROIDS; i++) ast_q[i]  <= '0;
    end else if (latch_en) begin
      ship_q <= decode(ship);
      for (int i = 0; i < MAX_SHOTS; i++)     shot_q[i] <= decode(shots[i*ENTITY_SIZE +: ENTITY_SIZE]);
      for (int i = 0; i < MAX_ASTEROIDS; i++) ast_q[i]  <= decode(asteroids[i*ENTITY_SIZE +: ENTITY_SIZE]);
    end else if (clear_en) begin
      shot_q[sidx_q].act <= 1'b0;
      ast_q[aidx_q].act  <= 1'b0;
    end
  end

  assign delete_shot      = del_q;
  assign delete_asteroid  = del_q;
  assign shot_address     = shot_addr_q;
  assign asteroid_address = ast_addr_q;
  assign ship_hit         = ship_hit_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign hit_count        = count_q;

endmodule

// File: tb/tb_collision_detector.sv
// tb/tb_collision_detector.sv - vector table plus scoreboard bench for collision_detector
module tb_collision_detector;

  localparam int E = 34;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [E-1:0]   ship;
  logic [3*E-1:0] shots;
  logic [4*E-1:0] asteroids;
  logic           ack;
  logic           delete_shot, delete_asteroid, ship_hit, busy, done;
  logic [1:0]     shot_address, asteroid_address;
  logic [7:0]     hit_count;

  collision_detector dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .ship             (ship),
    .shots            (shots),
    .asteroids        (asteroids),
    .ack              (ack),
    .delete_shot      (delete_shot),
    .shot_address     (shot_address),
    .delete_asteroid  (delete_asteroid),
    .asteroid_address (asteroid_address),
    .ship_hit         (ship_hit),
    .busy             (busy),
    .done             (done),
    .hit_count        (hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [E-1:0]     ship;
    logic [3*E-1:0]   shots;
    logic [4*E-1:0]   asts;
    int               n;
    logic [2:0][1:0]  ps;
    logic [2:0][1:0]  pa;
    int               exp_ship;
    int               exp_done;
    int               ack_dly;
    bit               mid_start;
    bit               scramble;
  } vec_t;

  typedef struct packed {
    logic [1:0] s;
    logic [1:0] a;
  } pair_t;

  pair_t sb[$];
  vec_t  vecs[8];
  int    checks = 0;
  int    errors = 0;
  int    exp_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [E-1:0] mk(input bit a, input int x, input int y);
    logic [E-1:0] r;
    r        = '0;
    r[33]    = a;
    r[25:16] = y[9:0];
    r[15:6]  = x[9:0];
    return r;
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v.ship = '0; v.shots = '0; v.asts = '0; v.n = 0; v.ps = '0; v.pa = '0;
    v.exp_ship = 0; v.exp_done = 18; v.ack_dly = 0; v.mid_start = 0; v.scramble = 0;
    return v;
  endfunction

  task automatic run_scan(input vec_t v, input string tag);
    int    cyc, rep, ship_cnt, done_cyc;
    bit    busy_bad, sync_bad, stable_bad;
    logic [1:0] hs, ha;
    pair_t p;
    cyc = 0; rep = 0; ship_cnt = 0; done_cyc = -1;
    busy_bad = 0; sync_bad = 0; stable_bad = 0; hs = '0; ha = '0;
    ship = v.ship; shots = v.shots; asteroids = v.asts; ack = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      p.s = v.ps[i];
      p.a = v.pa[i];
      sb.push_back(p);
    end
    @(negedge clk);
    start = 1'b1;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (v.mid_start && cyc == 5) start = 1'b1;
      if (v.mid_start && cyc == 6) start = 1'b0;
      if (v.scramble && cyc == 2) begin
        ship = '1; shots = '1; asteroids = '1;
      end
      if (busy !== 1'b1) busy_bad = 1;
      if (delete_shot !== delete_asteroid) sync_bad = 1;
      if (delete_shot === 1'b1) begin
        rep++;
        if (rep == 1) begin
          hs = shot_address;
          ha = asteroid_address;
          if (sb.size() == 0) chk({tag, " unexpected delete"}, 1, 0);
          else begin
            p = sb.pop_front();
            chk({tag, " shot_address"}, int'(shot_address), int'(p.s));
            chk({tag, " asteroid_address"}, int'(asteroid_address), int'(p.a));
          end
        end else if (shot_address !== hs || asteroid_address !== ha) begin
          stable_bad = 1;
        end
        ack = (rep >= v.ack_dly + 1);
      end else begin
        rep = 0;
        ack = 1'b0;
      end
      if (ship_hit === 1'b1) ship_cnt++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    ack = 1'b0;
    exp_count = (exp_count + v.n > 255) ? 255 : exp_count + v.n;
    chk({tag, " done cycle"}, done_cyc, v.exp_done);
    chk({tag, " ship_hit pulses"}, ship_cnt, v.exp_ship);
    chk({tag, " missing reports"}, sb.size(), 0);
    sb.delete();
    chk({tag, " busy held"}, int'(busy_bad), 0);
    chk({tag, " delete sync"}, int'(sync_bad), 0);
    chk({tag, " address stable"}, int'(stable_bad), 0);
    chk({tag, " hit_count"}, int'(hit_count), exp_count);
    @(negedge clk);
    chk({tag, " idle after done"}, int'({busy, done, ship_hit, delete_shot}), 0);
  endtask

  task automatic build_vectors();
    for (int i = 0; i < 8; i++) vecs[i] = blank();
    // 0: everything inactive
    // 1: shot1 (100,50) vs asteroid2 (92,44), slow ack
    vecs[1].shots[E +: E]    = mk(1, 100, 50);
    vecs[1].asts[2*E +: E]   = mk(1, 92, 44);
    vecs[1].n = 1; vecs[1].ps[0] = 2'd1; vecs[1].pa[0] = 2'd2;
    vecs[1].ack_dly = 3; vecs[1].exp_done = 22;
    // 2: shot edge exactly at asteroid right edge
    vecs[2].shots[0 +: E]    = mk(1, 116, 50);
    vecs[2].asts[0 +: E]     = mk(1, 100, 50);
    // 3: one pixel inside
    vecs[3].shots[0 +: E]    = mk(1, 115, 50);
    vecs[3].asts[0 +: E]     = mk(1, 100, 50);
    vecs[3].n = 1; vecs[3].exp_done = 19;
    // 4: ship hits asteroid0 first, asteroid1 skipped
    vecs[4].ship             = mk(1, 10, 10);
    vecs[4].asts[0 +: E]     = mk(1, 14, 14);
    vecs[4].asts[E +: E]     = mk(1, 12, 12);
    vecs[4].exp_ship = 1; vecs[4].exp_done = 15;
    // 5: shot0 overlaps asteroids 0 and 1, start re-pulsed mid-scan
    vecs[5].shots[0 +: E]    = mk(1, 50, 50);
    vecs[5].asts[0 +: E]     = mk(1, 45, 45);
    vecs[5].asts[E +: E]     = mk(1, 40, 48);
    vecs[5].n = 1; vecs[5].ack_dly = 1; vecs[5].exp_done = 20; vecs[5].mid_start = 1;
    // 6: inputs scrambled after the snapshot
    vecs[6].ship             = mk(1, 600, 600);
    vecs[6].shots[2*E +: E]  = mk(1, 300, 300);
    vecs[6].asts[3*E +: E]   = mk(1, 301, 301);
    vecs[6].n = 1; vecs[6].ps[0] = 2'd2; vecs[6].pa[0] = 2'd3;
    vecs[6].exp_done = 19; vecs[6].scramble = 1;
    // 7: two shot hits then a ship hit on asteroid1
    vecs[7].ship             = mk(1, 702, 702);
    vecs[7].shots[0 +: E]    = mk(1, 200, 200);
    vecs[7].shots[2*E +: E]  = mk(1, 400, 400);
    vecs[7].asts[0 +: E]     = mk(1, 395, 398);
    vecs[7].asts[E +: E]     = mk(1, 700, 700);
    vecs[7].asts[3*E +: E]   = mk(1, 195, 195);
    vecs[7].n = 2; vecs[7].ps[0] = 2'd0; vecs[7].pa[0] = 2'd3;
    vecs[7].ps[1] = 2'd2; vecs[7].pa[1] = 2'd0;
    vecs[7].ack_dly = 2; vecs[7].exp_ship = 1; vecs[7].exp_done = 22;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wait_cyc;
    bit   woke;
    vec_t sat;
    reset_n = 1'b0; start = 1'b0; ack = 1'b0;
    ship = '0; shots = '0; asteroids = '0;
    build_vectors();
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset deletes", int'({delete_shot, delete_asteroid, ship_hit}), 0);
    chk("reset hit_count", int'(hit_count), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_scan(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while a delete request is pending.
    ship = vecs[1].ship; shots = vecs[1].shots; asteroids = vecs[1].asts; ack = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (delete_shot !== 1'b1 && wait_cyc < 40) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("rst reached REPORT", int'(delete_shot), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst delete_shot", int'(delete_shot), 0);
    chk("rst delete_asteroid", int'(delete_asteroid), 0);
    chk("rst addresses", int'({shot_address, asteroid_address}), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done ship_hit", int'({done, ship_hit}), 0);
    chk("rst hit_count", int'(hit_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_count = 0;
    woke = 0;
    repeat (25) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) woke = 1;
    end
    chk("rst stays idle", int'(woke), 0);
    run_scan(vecs[3], "post-reset");

    // Saturation: three hits per scan until the counter pins at 255.
    sat = blank();
    sat.shots[0 +: E]   = mk(1, 100, 100);
    sat.shots[E +: E]   = mk(1, 300, 300);
    sat.shots[2*E +: E] = mk(1, 500, 500);
    sat.asts[0 +: E]    = mk(1, 100, 100);
    sat.asts[E +: E]    = mk(1, 300, 300);
    sat.asts[2*E +: E]  = mk(1, 500, 500);
    sat.n = 3;
    sat.ps[0] = 2'd0; sat.pa[0] = 2'd0;
    sat.ps[1] = 2'd1; sat.pa[1] = 2'd1;
    sat.ps[2] = 2'd2; sat.pa[2] = 2'd2;
    sat.exp_done = 21;
    for (int i = 0; i < 86; i++) run_scan(sat, $sformatf("sat%0d", i));
    chk("saturated hit_count", int'(hit_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameters, one per line:
- ENTITY_SIZE, 34, entity record width.
- MAX_SHOTS, 3, number of shot records.
- MAX_ASTEROIDS, 4, number of asteroid records.
- SHOT_SIZE, 2, shot box edge in pixels.
- ASTEROID_SIZE, 16, asteroid box edge in pixels.
- SHIP_SIZE, 8, ship box edge in pixels.
REQ-002 SHALL decode every entity record as: [33] active, [25:16] y, [15:6] x, [5:0] direction, [32:26] ignored.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  scan request; sampled only in IDLE.
- ship  in  ENTITY_SIZE  ship record.
- shots  in  MAX_SHOTS*ENTITY_SIZE  packed shot records; index 0 is in the LSBs.
- asteroids  in  MAX_ASTEROIDS*ENTITY_SIZE  packed asteroid records.
- ack  in  1  controllers have consumed the current delete request.
- delete_shot  out  1  request to delete the shot at shot_address.
- shot_address  out  2  index of the shot to delete.
- delete_asteroid  out  1  request to delete the asteroid at asteroid_address.
- asteroid_address  out  2  index of the asteroid to delete.
- ship_hit  out  1  one-cycle pulse: the ship overlaps an asteroid.
- busy  out  1  a scan is in progress.
- done  out  1  one-cycle pulse: the scan is complete.
- hit_count  out  8  saturating count of shot-asteroid hits.

Function
REQ-004 SHALL implement an FSM with states IDLE, LATCH, CHECK, REPORT and DONE.
REQ-005 IDLE: when start=1 at an edge, SHALL go to LATCH; busy=0 in IDLE and busy=1 in every other state.
REQ-006 LATCH: SHALL snapshot ship, shots and asteroids into internal registers in one cycle, reset the pair index to 0, then go to CHECK.
REQ-007 CHECK: SHALL evaluate exactly one pair per cycle from the snapshot, in this order:
- shot s vs asteroid a, s-major: (0,0),(0,1)...(MAX_SHOTS-1,MAX_ASTEROIDS-1);
- then the ship vs asteroid 0..MAX_ASTEROIDS-1.
REQ-008 A pair SHALL hit only if both snapshot active bits are 1 and the boxes overlap.
- Overlap: xa < xb+Sb AND xb < xa+Sa AND ya < yb+Sb AND yb < ya+Sa.
- Sums SHALL be computed at 11 bits with no wrap-around; S is the box edge size for each entity.
REQ-009 On a shot-asteroid hit SHALL go to REPORT next cycle.
- In REPORT, delete_shot=1 and delete_asteroid=1, with addresses equal to the hit pair.
- Outputs SHALL be held stable until an edge with ack=1.
REQ-010 On the ack edge SHALL:
- clear both snapshot active bits;
- increment hit_count, saturating at 255;
- deassert both delete outputs;
- return to CHECK at the next pair.
A consumed shot or asteroid therefore cannot hit again in the same scan.
REQ-011 On a ship-asteroid hit SHALL:
- pulse ship_hit for exactly one cycle;
- skip the remaining ship pairs;
- not request an asteroid deletion.
REQ-012 After the last pair (or the ship hit) SHALL go to DONE, assert done for exactly one cycle, then return to IDLE.
REQ-013 Scan with no hits: done SHALL assert in the 18th cycle after the edge that samples start (1 LATCH + 16 CHECK + DONE). Each REPORT visit SHALL add its own duration.
REQ-014 start SHALL be ignored while busy=1; ack SHALL be ignored outside REPORT.
REQ-015 Input changes after LATCH SHALL NOT affect the current scan.
REQ-016 delete_shot and delete_asteroid SHALL always assert together and deassert together.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 reset_n=0 SHALL immediately, independent of clk:
- force state IDLE;
- clear the snapshot and pair index;
- drive delete_shot, delete_asteroid, ship_hit, busy and done to 0;
- drive shot_address, asteroid_address and hit_count to 0.
REQ-019 Reset during REPORT SHALL drop the pending request without incrementing hit_count; the first scan after reset SHALL require a new start.

Verification
REQ-020 No hits:
- Stimulus: ship inactive; all shots inactive; start pulse.
- Response: busy=1 for 18 cycles; done pulses once; no delete or ship_hit.
REQ-021 Single hit:
- Stimulus: shot1 at (100,50), active; asteroid2 at (92,44), active; start; ack held 0 for 3 cycles, then 1.
- Response: delete_shot=1 and delete_asteroid=1 with shot_address=1, asteroid_address=2, stable until ack; then hit_count=1; done 1 cycle after the scan ends.
REQ-022 Boundary:
- Stimulus: shot at (116,50), asteroid at (100,50), since 116 = 100+16.
- Response: no hit.
- Stimulus: shot moved to (115,50).
- Response: hit.
REQ-023 Ship hit:
- Stimulus: ship at (10,10), active; asteroid0 at (14,14); asteroid1 at (12,12).
- Response: exactly one ship_hit pulse; no deletes; done follows.
REQ-024 Double-hit prevention and ignored start:
- Stimulus: shot0 overlaps asteroids 0 and 1; start pulsed again mid-scan.
- Response: only the pair (0,0) is reported; the second start is ignored; hit_count=1.
REQ-025 Reset mid-scan:
- Stimulus: reset_n=0 while in REPORT.
- Response: all outputs 0 immediately; hit_count=0; IDLE until a new start.
